ram_basic_ctrl: RTL and testbench

Synchronous initiator for the single-port 64x8 `ram_basic` memory. It accepts read and write requests on a valid/ready interface and buffers them in a small command FIFO. It sequences each request onto the RAM's CS/WR/addr/data_in bus with a fixed access window, then returns read data on a one-cycle response strobe. It sits between on-chip logic and `ram_basic`, and replaces hand-driven task stimulus as the only agent driving the RAM bus.

---
 rtl/ram_basic_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_basic_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_basic_ctrl.sv
// Request-driven initiator for the 64x8 ram_basic: buffers requests in a small FIFO
// and plays each one onto the CS/WR/addr/data_in bus with a fixed CS-low window.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | bus parked (CS = 1), waiting for a queued request
//  ACCESS | CS = 0, bus holds the popped entry, counter runs down to 0
//  GAP    | one CS-high cycle between accesses, may pop the next entry
module ram_basic_ctrl #(
   parameter int ACC_CYC    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wr,
   input  logic [5:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       wr_done,
   output logic       busy,
   output logic       CS,
   output logic       WR,
   output logic [5:0] addr,
   output logic [7:0] data_in,
   input  logic [7:0] data_out,
   output logic       en
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GAP} state_t;

   state_t        state, state_nxt;
   logic [14:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop, load, done;
   logic [3:0]    cnt;
   logic [14:0]   head;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign push      = req_valid & ~full;
   assign head      = fifo_mem[rd_ptr];
   assign req_ready = ~full;
   assign busy      = (state != S_IDLE) | ~empty;
   assign en        = 1'b1;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {req_wr, req_addr, req_wdata};
   end

   // Push and pop may coincide; count then stays put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               load      = 1'b1;
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt == 4'd0) begin
               done      = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (!empty) begin
               pop       = 1'b1;
               load      = 1'b1;
               state_nxt = S_ACCESS;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // WR/addr/data_in only move on the edge that drops CS, so they are stable
   // across the whole window and through the following gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         CS        <= 1'b1;
         WR        <= 1'b0;
         addr      <= '0;
         data_in   <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         wr_done   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
         if (load) begin
            CS                  <= 1'b0;
            {WR, addr, data_in} <= head;
            cnt                 <= 4'(ACC_CYC - 1);
         end else if (done) begin
            CS <= 1'b1;
            if (WR) begin
               wr_done <= 1'b1;
            end else begin
               rsp_valid <= 1'b1;
               rsp_data  <= data_out;
            end
         end else if (state == S_ACCESS) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ram_basic_ctrl.sv
// Directed bench for ram_basic_ctrl: instance 0 uses ACC_CYC = 2, instance 1 uses
// ACC_CYC = 1; each drives a small behavioural RAM model.
module tb_ram_basic_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid [2];
   logic       req_ready [2];
   logic       req_wr    [2];
   logic [5:0] req_addr  [2];
   logic [7:0] req_wdata [2];
   logic       rsp_valid [2];
   logic [7:0] rsp_data  [2];
   logic       wr_done   [2];
   logic       busy      [2];
   logic       cs        [2];
   logic       wr        [2];
   logic [5:0] addr      [2];
   logic [7:0] din       [2];
   logic [7:0] dout      [2];
   logic       en        [2];
   logic [7:0] mem0 [64];
   logic [7:0] mem1 [64];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_basic_ctrl #(.ACC_CYC(2), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .wr_done(wr_done[0]),
      .busy(busy[0]), .CS(cs[0]), .WR(wr[0]), .addr(addr[0]), .data_in(din[0]),
      .data_out(dout[0]), .en(en[0]));

   ram_basic_ctrl #(.ACC_CYC(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .wr_done(wr_done[1]),
      .busy(busy[1]), .CS(cs[1]), .WR(wr[1]), .addr(addr[1]), .data_in(din[1]),
      .data_out(dout[1]), .en(en[1]));

   // RAM models: zero-initialised, write while selected, combinational read.
   initial begin
      for (int i = 0; i < 64; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end
   end
   always @(posedge clk) if (!cs[0] && wr[0]) mem0[addr[0]] <= din[0];
   always @(posedge clk) if (!cs[1] && wr[1]) mem1[addr[1]] <= din[1];
   assign dout[0] = mem0[addr[0]];
   assign dout[1] = mem1[addr[1]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One isolated request on instance d, checked cycle by cycle.
   task automatic do_req(input int d, input logic w, input logic [5:0] a,
                         input logic [7:0] wd, input logic [7:0] ed);
      int n;
      n = (d == 0) ? 2 : 1;
      req_wr[d]    = w;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      chk("ready_idle", 32'(req_ready[d]), 32'd1);
      tick();
      req_valid[d] = 1'b0;
      chk("cs_at_accept", 32'(cs[d]), 32'd1);
      chk("busy_at_accept", 32'(busy[d]), 32'd1);
      for (int k = 1; k <= n + 1; k++) begin
         tick();
         if (k <= n) begin
            chk("cs_window", 32'(cs[d]), 32'd0);
            chk("wr_window", 32'(wr[d]), 32'(w));
            chk("addr_window", 32'(addr[d]), 32'(a));
            if (w) chk("data_in_window", 32'(din[d]), 32'(wd));
            chk("no_early_strobe", 32'(rsp_valid[d] | wr_done[d]), 32'd0);
         end else begin
            chk("cs_release", 32'(cs[d]), 32'd1);
            chk("wr_done", 32'(wr_done[d]), 32'(w));
            chk("rsp_valid", 32'(rsp_valid[d]), 32'(!w));
            if (!w) chk("rsp_data", 32'(rsp_data[d]), 32'(ed));
         end
         chk("bus_known", 32'($isunknown({cs[d], wr[d], addr[d], din[d]})), 32'd0);
      end
      tick();
      chk("strobe_single", 32'(rsp_valid[d] | wr_done[d]), 32'd0);
      chk("busy_end", 32'(busy[d]), 32'd0);
   endtask

   typedef struct {
      int         d;
      logic       w;
      logic [5:0] a;
      logic [7:0] wd;
      logic [7:0] ed;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int         idx;
      logic       rdy;
      logic       exp_cs;
      logic [5:0] ba [7];
      logic [7:0] bd [7];
      logic       bw [7];

      vecs[0] = '{0, 1'b1, 6'h00, 8'hAA, 8'h00};
      vecs[1] = '{0, 1'b0, 6'h00, 8'h00, 8'hAA};
      vecs[2] = '{0, 1'b1, 6'h3F, 8'hFF, 8'h00};
      vecs[3] = '{0, 1'b0, 6'h3F, 8'h00, 8'hFF};
      vecs[4] = '{0, 1'b0, 6'h1F, 8'h00, 8'h00};
      vecs[5] = '{1, 1'b1, 6'h07, 8'h77, 8'h00};
      vecs[6] = '{1, 1'b0, 6'h07, 8'h00, 8'h77};
      vecs[7] = '{1, 1'b0, 6'h3F, 8'h00, 8'h00};

      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_wr[d]    = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
      end

      // Reset values.
      tick();
      tick();
      chk("rst_cs", 32'(cs[0]), 32'd1);
      chk("rst_wr", 32'(wr[0]), 32'd0);
      chk("rst_addr", 32'(addr[0]), 32'd0);
      chk("rst_data_in", 32'(din[0]), 32'd0);
      chk("rst_en", 32'(en[0]), 32'd1);
      chk("rst_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data[0]), 32'd0);
      chk("rst_wr_done", 32'(wr_done[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_cs1", 32'(cs[1]), 32'd1);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++)
         do_req(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ed);

      // Seven requests offered back-to-back; the source holds each until accepted.
      bw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      ba = '{6'h10, 6'h10, 6'h20, 6'h20, 6'h30, 6'h30, 6'h10};
      bd = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h11};
      idx = 0;
      for (int e = 1; e <= 25; e++) begin
         req_valid[0] = (idx < 7);
         if (idx < 7) begin
            req_wr[0]    = bw[idx];
            req_addr[0]  = ba[idx];
            req_wdata[0] = bw[idx] ? bd[idx] : 8'h00;
         end
         rdy = req_ready[0];
         tick();
         if (req_valid[0] && rdy) idx++;
         if (e <= 12)
            chk("b2b_ready", 32'(req_ready[0]), 32'(!(e == 6 || e == 7 || e == 9 || e == 10)));
         chk("b2b_wr_done", 32'(wr_done[0]), 32'(e == 4 || e == 10 || e == 16));
         chk("b2b_rsp_valid", 32'(rsp_valid[0]), 32'(e == 7 || e == 13 || e == 19 || e == 22));
         if (e == 7 || e == 22) chk("b2b_rsp_data", 32'(rsp_data[0]), 32'h11);
         if (e == 13) chk("b2b_rsp_data", 32'(rsp_data[0]), 32'h22);
         if (e == 19) chk("b2b_rsp_data", 32'(rsp_data[0]), 32'h33);
         exp_cs = !(e >= 2 && e <= 21 && ((e - 2) % 3) != 2);
         chk("b2b_cs", 32'(cs[0]), 32'(exp_cs));
         chk("b2b_busy", 32'(busy[0]), 32'(e <= 22));
      end
      req_valid[0] = 1'b0;
      chk("b2b_all_accepted", 32'(idx), 32'd7);

      // Reset in the second ACCESS cycle of a read with two requests queued.
      req_wr[0] = 1'b0; req_addr[0] = 6'h00; req_valid[0] = 1'b1;
      tick();
      req_wr[0] = 1'b1; req_addr[0] = 6'h01; req_wdata[0] = 8'h99;
      tick();
      req_wr[0] = 1'b0; req_addr[0] = 6'h02;
      tick();
      req_valid[0] = 1'b0;
      chk("abort_in_access", 32'(cs[0]), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("abort_cs_async", 32'(cs[0]), 32'd1);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_ready", 32'(req_ready[0]), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("abort_no_strobe", 32'(rsp_valid[0] | wr_done[0]), 32'd0);
         chk("abort_cs_idle", 32'(cs[0]), 32'd1);
         chk("abort_busy_idle", 32'(busy[0]), 32'd0);
      end
      do_req(0, 1'b1, 6'h05, 8'h55, 8'h00);
      do_req(0, 1'b0, 6'h05, 8'h00, 8'h55);
      do_req(0, 1'b0, 6'h01, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
